adc_spi_master: RTL

ADC_SPI_MASTER -- requirements
Module: adc_spi_master

---
 rtl/adc_spi_pkg.sv | 33 +++
 rtl/adc_spi_clk_div.sv | 39 +++
 rtl/adc_spi_master.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/adc_spi_pkg.sv
// ---------------------------------------------------------------------------
// adc_spi_pkg
// Shared definitions for the ADC SPI master:
//   spi_state_t  - transfer sequencer states
//   MAX_LNG      - longest high/low part in bits
//   MIN_PRESC    - smallest usable SCLK prescaler
//   clampLng     - limits a requested part length to MAX_LNG
//   halfPeriod   - converts the prescaler into a half-period in clk cycles
// ---------------------------------------------------------------------------
package adc_spi_pkg;

  localparam int MAX_LNG   = 16;
  localparam int MIN_PRESC = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_SHIFT_H,
    ST_SHIFT_L,
    ST_CS_HOLD
  } spi_state_t;

  // Lengths above MAX_LNG would walk off the 16-bit data words.
  function automatic logic [4:0] clampLng(input logic [4:0] lng);
    return (lng > 5'(MAX_LNG)) ? 5'(MAX_LNG) : lng;
  endfunction

  // Prescalers of 0 and 1 cannot make a half-period, so they behave like 2.
  function automatic logic [7:0] halfPeriod(input logic [7:0] presc);
    return (presc < 8'(MIN_PRESC)) ? 8'd1 : (presc >> 1);
  endfunction

endpackage

// File: rtl/adc_spi_clk_div.sv
// ---------------------------------------------------------------------------
// adc_spi_clk_div
// Produces a one-cycle tick every i_half cycles while enabled. The transfer
// sequencer advances only on these ticks.
// Ports:
//   i_clk   - system clock
//   i_rst   - synchronous active-high reset
//   i_clr   - restart the count (asserted when a transfer is accepted)
//   i_en    - count enable (high while a transfer is running)
//   i_half  - half-period length in clock cycles (>= 1)
//   o_tick  - high for the last cycle of every half-period
// ---------------------------------------------------------------------------
module adc_spi_clk_div (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_clr,
  input  logic       i_en,
  input  logic [7:0] i_half,
  output logic       o_tick
);

  logic [7:0] r_cnt;
  logic       w_atEnd;

  assign w_atEnd = (r_cnt == (i_half - 8'd1));
  assign o_tick  = i_en && w_atEnd;

  // Free-running half-period counter; it wraps on the tick so every
  // half-period is exactly i_half cycles long, starting from a clean zero
  // at each accepted transfer.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= 8'd0;
    end else if (i_en) begin
      r_cnt <= w_atEnd ? 8'd0 : (r_cnt + 8'd1);
    end
  end

endmodule

// File: rtl/adc_spi_master.sv
// ---------------------------------------------------------------------------
// adc_spi_master
// SPI master for ADC register access. A transfer sends a high (address) part
// followed by a low (data) part, MSB first, framed by an active-low chip
// select with one half-period of setup and hold around the SCLK pulses.
// Optional feature macro: ADC_SPI_READBACK_EN enables reads of the low part
// (MOSI tristated, MISO shifted into dat_rd_l_o).
// Ports:
//   clk_i, rst_i          - clock, synchronous active-high reset
//   spi_start_i           - one-cycle transfer request (ignored while busy)
//   dat_wr_h_i/dat_wr_l_i - high/low part write data
//   cfg_rw_i              - 1 = read the low part
//   cfg_cs_act_i          - one-hot chip select to assert
//   cfg_h_lng_i/_l_lng_i  - high/low part bit counts (0 skips, >16 -> 16)
//   cfg_clk_presc_i       - SCLK period in clk cycles
//   cfg_clk_wr_edg_i      - MOSI changes on 1 = falling, 0 = rising SCLK
//   cfg_clk_rd_edg_i      - MISO sampled on 1 = rising, 0 = falling SCLK
//   cfg_clk_idle_i        - SCLK idle level
//   spi_miso_i            - serial input
//   spi_cs_o, spi_clk_o, spi_mosi_o, spi_mosi_t - SPI pins (mosi_t 1 = hi-Z)
//   dat_rd_l_o            - captured read data, right-aligned
//   sts_spi_busy_o        - transfer in progress
// ---------------------------------------------------------------------------
module adc_spi_master #(
  parameter int NUM_OF_CS = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 spi_start_i,
  input  logic [15:0]          dat_wr_h_i,
  input  logic [15:0]          dat_wr_l_i,
  input  logic                 cfg_rw_i,
  input  logic [NUM_OF_CS-1:0] cfg_cs_act_i,
  input  logic [4:0]           cfg_h_lng_i,
  input  logic [4:0]           cfg_l_lng_i,
  input  logic [7:0]           cfg_clk_presc_i,
  input  logic                 cfg_clk_wr_edg_i,
  input  logic                 cfg_clk_rd_edg_i,
  input  logic                 cfg_clk_idle_i,
  input  logic                 spi_miso_i,
  output logic [NUM_OF_CS-1:0] spi_cs_o,
  output logic                 spi_clk_o,
  output logic                 spi_mosi_o,
  output logic                 spi_mosi_t,
  output logic [15:0]          dat_rd_l_o,
  output logic                 sts_spi_busy_o
);

  import adc_spi_pkg::*;

  spi_state_t           r_state;
  spi_state_t           w_stateNext;
  logic [4:0]           r_bitCnt;
  logic [4:0]           w_bitCntNext;
  logic                 r_phase2;
  logic                 w_phase2Next;
  logic                 w_start;
  logic                 w_tick;
  logic                 w_leadEdge;
  logic                 w_firstLead;
  logic                 w_trailEdge;
  logic                 w_shifting;

  logic [31:0]          r_txSr;
  logic [4:0]           r_hLng;
  logic [4:0]           r_lLng;
  logic [7:0]           r_halfPer;
  logic [NUM_OF_CS-1:0] r_csAct;
  logic                 r_idle;
  logic                 r_wrLead;

  logic [4:0]           w_hLngIn;
  logic [4:0]           w_lLngIn;
  logic [31:0]          w_hAl;
  logic [31:0]          w_lAl;
  logic [31:0]          w_txInit;

  adc_spi_clk_div u_clkDiv (
    .i_clk  (clk_i),
    .i_rst  (rst_i),
    .i_clr  (w_start),
    .i_en   (r_state != ST_IDLE),
    .i_half (r_halfPer),
    .o_tick (w_tick)
  );

  // Both parts are packed into one left-justified 32-bit word so MOSI is
  // always bit 31 and a single left shift moves to the next bit, across the
  // high/low boundary as well.
  assign w_hLngIn = clampLng(cfg_h_lng_i);
  assign w_lLngIn = clampLng(cfg_l_lng_i);
  assign w_hAl    = {dat_wr_h_i, 16'd0} << (5'd16 - w_hLngIn);
  assign w_lAl    = {dat_wr_l_i, 16'd0} << (5'd16 - w_lLngIn);
  assign w_txInit = w_hAl | (w_lAl >> w_hLngIn);

  assign w_shifting = (r_state == ST_SHIFT_H) || (r_state == ST_SHIFT_L);

  // State register; the bit counter and half-bit flag are part of the
  // sequencer state.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_bitCnt <= 5'd0;
      r_phase2 <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_bitCnt <= w_bitCntNext;
      r_phase2 <= w_phase2Next;
    end
  end

  // Next-state logic. Each bit is two half-periods: the first tick of a bit
  // is the trailing SCLK edge (back to idle), the second ends the bit and,
  // if another bit follows, is the next leading edge. The leading edge out
  // of CS_SETUP starts the first bit, which is already on MOSI.
  always_comb begin
    w_stateNext  = r_state;
    w_bitCntNext = r_bitCnt;
    w_phase2Next = r_phase2;
    w_start      = 1'b0;
    w_leadEdge   = 1'b0;
    w_firstLead  = 1'b0;
    w_trailEdge  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (spi_start_i) begin
          w_start     = 1'b1;
          w_stateNext = ST_CS_SETUP;
        end
      end
      ST_CS_SETUP: begin
        if (w_tick) begin
          w_phase2Next = 1'b0;
          if (r_hLng != 5'd0) begin
            w_stateNext  = ST_SHIFT_H;
            w_bitCntNext = r_hLng;
            w_leadEdge   = 1'b1;
            w_firstLead  = 1'b1;
          end else if (r_lLng != 5'd0) begin
            w_stateNext  = ST_SHIFT_L;
            w_bitCntNext = r_lLng;
            w_leadEdge   = 1'b1;
            w_firstLead  = 1'b1;
          end else begin
            w_stateNext = ST_CS_HOLD;
          end
        end
      end
      ST_SHIFT_H, ST_SHIFT_L: begin
        if (w_tick) begin
          if (!r_phase2) begin
            w_phase2Next = 1'b1;
            w_trailEdge  = 1'b1;
          end else begin
            w_phase2Next = 1'b0;
            if (r_bitCnt > 5'd1) begin
              w_bitCntNext = r_bitCnt - 5'd1;
              w_leadEdge   = 1'b1;
            end else if ((r_state == ST_SHIFT_H) && (r_lLng != 5'd0)) begin
              w_stateNext  = ST_SHIFT_L;
              w_bitCntNext = r_lLng;
              w_leadEdge   = 1'b1;
            end else begin
              w_stateNext = ST_CS_HOLD;
            end
          end
        end
      end
      ST_CS_HOLD: begin
        if (w_tick) begin
          w_stateNext = ST_IDLE;
        end
      end
      default: begin
        w_stateNext = ST_IDLE;
      end
    endcase
  end

  // Transfer configuration is frozen at the accepted start. The leading
  // SCLK edge is falling when idle is high, so "change on falling" means
  // leading-edge changes exactly when the idle level is high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_txSr    <= 32'd0;
      r_hLng    <= 5'd0;
      r_lLng    <= 5'd0;
      r_halfPer <= 8'd1;
      r_csAct   <= '0;
      r_idle    <= 1'b0;
      r_wrLead  <= 1'b0;
    end else if (w_start) begin
      r_txSr    <= w_txInit;
      r_hLng    <= w_hLngIn;
      r_lLng    <= w_lLngIn;
      r_halfPer <= halfPeriod(cfg_clk_presc_i);
      r_csAct   <= cfg_cs_act_i;
      r_idle    <= cfg_clk_idle_i;
      r_wrLead  <= (cfg_clk_wr_edg_i == cfg_clk_idle_i);
    end else if ((w_leadEdge && !w_firstLead && r_wrLead) ||
                 (w_trailEdge && !r_wrLead)) begin
      r_txSr <= {r_txSr[30:0], 1'b0};
    end
  end

  // SCLK is active for the first half of every bit and idle otherwise; in
  // IDLE it follows the live idle-level input.
  always_comb begin
    spi_clk_o = r_idle;
    if (r_state == ST_IDLE) begin
      spi_clk_o = cfg_clk_idle_i;
    end else if (w_shifting && !r_phase2) begin
      spi_clk_o = ~r_idle;
    end
  end

  assign spi_cs_o       = (r_state == ST_IDLE) ? '1 : ~r_csAct;
  assign sts_spi_busy_o = (r_state != ST_IDLE);
  assign spi_mosi_o     = (r_state != ST_IDLE) && r_txSr[31];

`ifdef ADC_SPI_READBACK_EN
  logic        r_rw;
  logic        r_rdLead;
  logic [15:0] r_rxSr;
  logic [15:0] r_datRd;
  logic        w_rxSample;

  // A low-part bit is sampled on its leading edge (the edge that enters or
  // stays in SHIFT_L) or on its trailing edge, depending on the read edge.
  assign w_rxSample = r_rw &&
                      ((w_leadEdge && r_rdLead && (w_stateNext == ST_SHIFT_L)) ||
                       (w_trailEdge && !r_rdLead && (r_state == ST_SHIFT_L)));

  // Read shift register starts at zero, so fewer than 16 captured bits come
  // out right-aligned and zero-extended. The result is published only as CS
  // deasserts.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rw     <= 1'b0;
      r_rdLead <= 1'b0;
      r_rxSr   <= 16'd0;
      r_datRd  <= 16'd0;
    end else if (w_start) begin
      r_rw     <= cfg_rw_i;
      r_rdLead <= (cfg_clk_rd_edg_i != cfg_clk_idle_i);
      r_rxSr   <= 16'd0;
    end else begin
      if (w_rxSample) begin
        r_rxSr <= {r_rxSr[14:0], spi_miso_i};
      end
      if ((r_state == ST_CS_HOLD) && w_tick && r_rw) begin
        r_datRd <= r_rxSr;
      end
    end
  end

  assign spi_mosi_t = r_rw && (r_state == ST_SHIFT_L);
  assign dat_rd_l_o = r_datRd;
`else
  logic w_unused;

  assign w_unused   = &{1'b0, spi_miso_i, cfg_rw_i, cfg_clk_rd_edg_i};
  assign spi_mosi_t = 1'b0;
  assign dat_rd_l_o = 16'd0;
`endif

endmodule
